// File: rtl/pacman_pkg.sv
// pacman_pkg -- shared definitions for the Pac-Man ROM loader.
//   state_e   : loader FSM states (IDLE, LOAD, CHECK, HOLD, RUN)
//   ROM_INDEX : ioctl download index that carries the game ROM
package pacman_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4
    } state_e;

    localparam logic [7:0] ROM_INDEX = 8'd0;

endpackage

// File: rtl/pacman_rom_loader_reset_stretch.sv
// reset_stretch -- down-counter that holds the core in reset.
// Ports:
//   clk_sys  in   system clock
//   reset    in   asynchronous active-high reset
//   trigger  in   count enable (high while the loader sits in HOLD)
//   load     in   (re)start the stretch; wins over trigger
//   active   out  more HOLD cycles remain after the current one
// Loading HOLD_CYCLES-1 makes the cycle in which active reads 0 the last
// HOLD cycle, so HOLD lasts exactly HOLD_CYCLES cycles after the last load.
module reset_stretch #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic trigger,
    input  logic load,
    output logic active
);
    localparam int CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = RELOAD;
        else if (trigger && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign active = (cnt_q != '0);

endmodule

// File: rtl/pacman_rom_loader.sv
// pacman_rom_loader -- accepts the index-0 ioctl download, forwards bytes to
// the core's ROM write port, validates the byte count and stretches the core
// reset after a good load or an OSD/board reset request.
// Ports:
//   clk_sys, reset                       clock, async active-high reset
//   ioctl_downl/_index/_wr/_addr/_dout   download interface
//   status_reset, button_reset           level-sensitive reset requests
//   dn_addr, dn_data, dn_wr              registered ROM write port
//   core_reset                           reset to the game core (low only in RUN)
//   rom_loaded                           a valid ROM has been received
//   load_err                             last download failed validation (sticky)
//   csum                                 mod-256 sum of accepted bytes
// Optional feature: define ROM_LOADER_CSUM_EN to build the checksum adder;
// otherwise csum is tied to zero.
module pacman_rom_loader
    import pacman_pkg::*;
#(
    parameter logic [16:0] ROM_BYTES   = 17'h10000,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        status_reset,
    input  logic        button_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        rom_loaded,
    output logic        load_err,
    output logic [7:0]  csum
);
    state_e      state_q, state_d;
    logic        downl_q;
    logic [16:0] cnt_q;
    logic        ovf_q;
    logic        rom_loaded_q, rom_loaded_d;
    logic        load_err_q, load_err_d;
    logic        core_reset_q;
    logic        dn_wr_q;
    logic [15:0] dn_addr_q;
    logic [7:0]  dn_data_q;

    logic dl_rise, dl_fall, rst_req, rom_wr, in_range, accept, drop, image_ok;
    logic start_dl, hold_load, hold_active;

    assign dl_rise  = ioctl_downl & ~downl_q;
    assign dl_fall  = ~ioctl_downl & downl_q;
    assign rst_req  = status_reset | button_reset;
    assign rom_wr   = (state_q == LOAD) && ioctl_wr && (ioctl_index == ROM_INDEX);
    assign in_range = ioctl_addr < {8'd0, ROM_BYTES};
    assign accept   = rom_wr & in_range;
    assign drop     = rom_wr & ~in_range;
    assign image_ok = (cnt_q == ROM_BYTES) && !ovf_q;

    always_comb begin
        state_d      = state_q;
        start_dl     = 1'b0;
        hold_load    = 1'b0;
        rom_loaded_d = rom_loaded_q;
        load_err_d   = load_err_q;
        case (state_q)
            IDLE: if (dl_rise) begin
                state_d  = LOAD;
                start_dl = 1'b1;
            end
            LOAD: if (dl_fall) state_d = CHECK;
            CHECK: begin
                if (image_ok) begin
                    rom_loaded_d = 1'b1;
                    hold_load    = 1'b1;
                    state_d      = HOLD;
                end else begin
                    load_err_d   = 1'b1;
                    rom_loaded_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            HOLD: begin
                if (dl_rise) begin
                    state_d  = LOAD;
                    start_dl = 1'b1;
                end else if (rst_req) begin
                    // a held request keeps restarting the stretch
                    hold_load = 1'b1;
                end else if (!hold_active) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dl_rise) begin
                    state_d  = LOAD;
                    start_dl = 1'b1;
                end else if (rst_req) begin
                    hold_load = 1'b1;
                    state_d   = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_dl) begin
            rom_loaded_d = 1'b0;
            load_err_d   = 1'b0;
        end
    end

    reset_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_stretch (
        .clk_sys (clk_sys),
        .reset   (reset),
        .trigger (state_q == HOLD),
        .load    (hold_load),
        .active  (hold_active)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            downl_q      <= 1'b0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            rom_loaded_q <= 1'b0;
            load_err_q   <= 1'b0;
            core_reset_q <= 1'b1;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            downl_q      <= ioctl_downl;
            rom_loaded_q <= rom_loaded_d;
            load_err_q   <= load_err_d;
            // registered from next state so the core sees a clean level
            core_reset_q <= (state_d != RUN);
            dn_wr_q      <= accept;
            if (accept) begin
                dn_addr_q <= ioctl_addr[15:0];
                dn_data_q <= ioctl_dout;
            end
            if (start_dl) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (accept && cnt_q != ROM_BYTES) cnt_q <= cnt_q + 17'd1;
                if (drop)                         ovf_q <= 1'b1;
            end
        end
    end

`ifdef ROM_LOADER_CSUM_EN
    logic [7:0] csum_q;
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)         csum_q <= '0;
        else if (start_dl) csum_q <= '0;
        else if (accept)   csum_q <= csum_q + ioctl_dout;
    end
    assign csum = csum_q;
`else
    assign csum = 8'h00;
`endif

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign core_reset = core_reset_q;
    assign rom_loaded = rom_loaded_q;
    assign load_err   = load_err_q;

endmodule
